rectangle_share_encoder: RTL and testbench
==========================================

// Module: rectangle_share_encoder
// PURPOSE
//  Front end of the 3-share masked RECTANGLE datapath. Accepts one unmasked 64-bit state, splits each nibble into 3 Boolean shares
//  using internal LFSR randomness, and streams them nibble-serially into the 3-share S-box layer (in1/in2/in3 nibble inputs).
//  It is the share producer feeding the masked S-box: share1^share2^share3 == plaintext nibble, bit 3 = MSB (d), bit 0 = LSB (a).
// PARAMETERS
//  NIBBLES    16            nibbles per frame (state width = 4*NIBBLES)
//  LFSR_W     32            mask-generator LFSR width
//  LFSR_SEED  32'hACE1_2468 reset seed; also substituted for any all-zero seed
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          state offered on in_data
//  in_ready   out  1          encoder can capture a state
//  in_data    in   4*NIBBLES  unmasked state, nibble 0 = in_data[3:0]
//  out_valid  out  1          current beat's shares valid
//  out_ready  in   1          downstream accepts current beat
//  out_last   out  1          current beat is nibble NIBBLES-1
//  out1       out  4          share 1 = x ^ m1 ^ m2
//  out2       out  4          share 2 = m1
//  out3       out  4          share 3 = m2
//  busy       out  1          state != IDLE
//  seed_load  in   1          (SEED_LOAD_EN only) load LFSR from seed_data
//  seed_data  in   LFSR_W     (SEED_LOAD_EN only) new seed
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, cnt=0, lfsr=LFSR_SEED, out_valid=0, out_last=0, out1/2/3=0, busy=0; in_ready=1 once released.
//  - LFSR: Galois, taps 32'h8020_0003, shifts right; one "advance" = 8 unrolled steps. m1=lfsr[3:0], m2=lfsr[7:4] of pre-advance value.
//  - in_ready = (state==IDLE) && !seed_load (combinational). Capture on in_valid&&in_ready: data -> shift reg, cnt=0,
//    out1/2/3 registered from nibble 0 and current masks, lfsr advances, state -> SEND. out_valid=1 the next cycle (latency 1).
//  - SEND: out1/2/3, out_last registered and held stable while out_valid && !out_ready. On out_valid&&out_ready:
//    cnt<NIBBLES-1 -> cnt++, shift reg >>4, next nibble's shares registered, lfsr advances; cnt==NIBBLES-1 (out_last=1) ->
//    state IDLE, out_valid=0, out_last=0, shares cleared to 0, lfsr not advanced.
//  - Fresh masks per beat; lfsr advances only on capture and on accepted non-final beats. Shares are always register outputs.
//  - Frame throughput: capture -> 16 beats -> in_ready next cycle; min period NIBBLES+1 cycles. in_valid ignored in SEND.
//  - Reset mid-frame: frame abandoned, no partial completion, outputs per reset list.
//  - out_ready asserted with out_valid=0: no effect. cnt width = clog2(NIBBLES).
// CONFIGURATION
//  - SEED_LOAD_EN defined: seed_load/seed_data ports exist. In IDLE, seed_load=1 loads lfsr (zero seed -> LFSR_SEED) and has priority
//    over in_valid (in_ready=0 that cycle). seed_load in SEND is ignored.
//  - SEED_LOAD_EN undefined: ports absent, lfsr only initialised by reset; in_ready = (state==IDLE).
// STRUCTURE
//  - Package rectangle_mask_pkg: NIBBLE_W=4, N_SHARES=3, LFSR_TAPS=32'h8020_0003, LFSR_SEED default, state enum {IDLE, SEND}.
//  - Sub-module rectangle_lfsr8: combinational 8-step Galois advance (lfsr_in -> lfsr_out); instantiated once.
// TESTING
//  - Reset then in_data=64'hFEDC_BA98_7654_3210, out_ready=1: beats 0..15 recombine to 0..F, out_last only on beat 15, in_ready back after 17 cycles.
//  - Same frame, out_ready toggling 1/0 every cycle: shares and out_last unchanged while stalled, 16 distinct beats, 32 cycles.
//  - Two frames back-to-back (in_valid held): second capture on first cycle in_ready=1; no beat dropped or duplicated.
//  - Share check: for every beat out2==lfsr[3:0], out3==lfsr[7:4] of bit-exact model seeded 32'hACE1_2468; share pairs differ across beats.
//  - rst_n low at beat 7: out_valid=0, shares=0 immediately; after release new frame restarts at beat 0 with seed masks.
//  - SEED_LOAD_EN: seed_load with seed_data=0 and in_valid same cycle -> in_ready=0, lfsr=LFSR_SEED; capture next cycle.

Source files
------------

// File: rtl/rectangle_mask_pkg.sv
// Shared constants and types for the masked RECTANGLE share encoder.
package rectangle_mask_pkg;

  localparam int          NIBBLE_W          = 4;
  localparam int          N_SHARES          = 3;
  localparam logic [31:0] LFSR_TAPS         = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'hACE1_2468;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/rectangle_lfsr8.sv
// Combinational eight-step advance of a right-shifting Galois LFSR.
module rectangle_lfsr8 #(
  parameter int             W    = 32,
  parameter logic [W-1:0]   TAPS = W'(32'h8020_0003)
) (
  input  logic [W-1:0] lfsr_in,
  output logic [W-1:0] lfsr_out
);

  logic [W-1:0] s;

  always_comb begin
    s = lfsr_in;
    for (int i = 0; i < 8; i++) begin
      if (s[0]) s = (s >> 1) ^ TAPS;
      else      s = s >> 1;
    end
    lfsr_out = s;
  end

endmodule

// File: rtl/rectangle_share_encoder.sv
// Splits a 64-bit state into 3 Boolean shares and streams them one nibble per beat.
// Optional SEED_LOAD_EN adds seed_load/seed_data for reseeding the mask LFSR while idle.
module rectangle_share_encoder
  import rectangle_mask_pkg::*;
#(
  parameter int                NIBBLES   = 16,
  parameter int                LFSR_W    = 32,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(LFSR_SEED_DEFAULT)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [NIBBLE_W-1:0]         out1,
  output logic [NIBBLE_W-1:0]         out2,
  output logic [NIBBLE_W-1:0]         out3,
`ifdef SEED_LOAD_EN
  input  logic                        seed_load,
  input  logic [LFSR_W-1:0]           seed_data,
`endif
  output logic                        busy
);

  localparam int               DATA_W = NIBBLE_W * NIBBLES;
  localparam int               CNT_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(NIBBLES - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   shreg;
  logic [LFSR_W-1:0]   lfsr;
  logic [LFSR_W-1:0]   lfsr_adv;
  logic                seed_req;

  // {x ^ m1 ^ m2, m1, m2}
  function automatic logic [3*NIBBLE_W-1:0] share_split(
    input logic [NIBBLE_W-1:0] x,
    input logic [NIBBLE_W-1:0] m1,
    input logic [NIBBLE_W-1:0] m2
  );
    return {x ^ m1 ^ m2, m1, m2};
  endfunction

  rectangle_lfsr8 #(
    .W    (LFSR_W),
    .TAPS (LFSR_W'(LFSR_TAPS))
  ) u_lfsr8 (
    .lfsr_in  (lfsr),
    .lfsr_out (lfsr_adv)
  );

`ifdef SEED_LOAD_EN
  assign seed_req = seed_load;
`else
  assign seed_req = 1'b0;
`endif

  assign in_ready = (state == IDLE) && !seed_req;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      lfsr      <= LFSR_SEED;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (seed_req) begin
`ifdef SEED_LOAD_EN
            lfsr <= (seed_data == '0) ? LFSR_SEED : seed_data;
`endif
          end else if (in_valid) begin
            // shreg keeps the not-yet-sent nibbles, next one always at [3:0]
            shreg              <= in_data >> NIBBLE_W;
            cnt                <= '0;
            {out1, out2, out3} <= share_split(in_data[NIBBLE_W-1:0],
                                              lfsr[NIBBLE_W-1:0],
                                              lfsr[2*NIBBLE_W-1:NIBBLE_W]);
            lfsr               <= lfsr_adv;
            out_valid          <= 1'b1;
            out_last           <= (NIBBLES == 1);
            state              <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (cnt == LAST) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out1      <= '0;
              out2      <= '0;
              out3      <= '0;
            end else begin
              cnt                <= cnt + CNT_W'(1);
              shreg              <= shreg >> NIBBLE_W;
              {out1, out2, out3} <= share_split(shreg[NIBBLE_W-1:0],
                                                lfsr[NIBBLE_W-1:0],
                                                lfsr[2*NIBBLE_W-1:NIBBLE_W]);
              lfsr               <= lfsr_adv;
              out_last           <= ((cnt + CNT_W'(1)) == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rectangle_share_encoder.sv
// Directed bench for rectangle_share_encoder with a frame/queue-level reference model.
module tb_rectangle_share_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [3:0]  out1, out2, out3;
  logic        busy;
  logic        seed_load;
  logic [31:0] seed_data;

  rectangle_share_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
`ifdef SEED_LOAD_EN
    .seed_load (seed_load),
    .seed_data (seed_data),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // mask stream: tab[i] = LFSR value after i advances from the reset seed
  logic [31:0] tab [0:255];

  function automatic logic [31:0] adv8(input logic [31:0] v);
    logic [31:0] s;
    s = v;
    for (int i = 0; i < 8; i++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    return s;
  endfunction

  // reference model: queue of nibbles still owed downstream, beat index into mask stream
  logic [3:0] q[$];
  int         bd = 0;
  int         cyc = 0;
  int         cap_n = 0;
  int         cap_cyc [0:15];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      bd = 0;
    end else begin
      cyc++;
      if (q.size() == 0) begin
        if (seed_load) bd = 0;
        else if (in_valid) begin
          for (int k = 0; k < 16; k++) q.push_back(in_data[4*k +: 4]);
          cap_cyc[cap_n[3:0]] = cyc;
          cap_n++;
        end
      end else if (out_ready) begin
        void'(q.pop_front());
        bd++;
      end
    end
  end

  // beat log of accepted beats
  logic [3:0] lx [0:255];
  logic [3:0] l1 [0:255];
  logic [3:0] l2 [0:255];
  logic [3:0] l3 [0:255];
  int         log_n = 0;
  logic       stall_prev = 1'b0;
  logic [12:0] held;
  logic       act_busy;

  always @(negedge clk) begin
    if (rst_n) begin
      act_busy = (q.size() != 0);
      chk("in_ready", in_ready, !act_busy && !seed_load);
      chk("busy", busy, act_busy);
      chk("out_valid", out_valid, act_busy);
      if (act_busy) begin
        chk("recombine", out1 ^ out2 ^ out3, q[0]);
        chk("share2_m1", out2, tab[bd[7:0]][3:0]);
        chk("share3_m2", out3, tab[bd[7:0]][7:4]);
        chk("out_last", out_last, q.size() == 1);
      end else begin
        chk("idle_zero", {out_last, out1, out2, out3}, 13'd0);
      end
      if (stall_prev) chk("stall_hold", {out_last, out1, out2, out3}, held);
      stall_prev = out_valid && !out_ready;
      held       = {out_last, out1, out2, out3};
      if (out_valid && out_ready) begin
        lx[log_n[7:0]] = out1 ^ out2 ^ out3;
        l1[log_n[7:0]] = out1;
        l2[log_n[7:0]] = out2;
        l3[log_n[7:0]] = out3;
        log_n++;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 60) begin
      tick();
      n++;
    end
  endtask

  int n, base, vcnt, c0;
  logic ph;

  initial begin
    tab[0] = 32'hACE1_2468;
    for (int i = 1; i < 256; i++) tab[i] = adv8(tab[i-1]);
    chk("model_tab1", tab[1], 32'h78B2_E125);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    seed_load = 1'b0; seed_data = '0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_shares", {out_last, out1, out2, out3}, 13'd0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    tick();

    // frame with continuous out_ready
    base = log_n;
    out_ready = 1'b1; in_data = 64'hFEDC_BA98_7654_3210; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_ready(n);
    chk("frame_period", n + 1, 17);
    chk("frame_beats", log_n - base, 16);
    for (int k = 0; k < 16; k++) chk("beat_value", lx[(base + k) & 255], k);
    chk("beat0_shares", {l1[base & 255], l2[base & 255], l3[base & 255]}, 12'hE86);
    chk("beat1_shares", {l1[(base+1) & 255], l2[(base+1) & 255], l3[(base+1) & 255]}, 12'h652);

    // same frame, out_ready toggling, stalled on the first valid cycle
    base = log_n; vcnt = 0; ph = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid && n < 80) begin
      vcnt++;
      out_ready = ph;
      ph = ~ph;
      tick();
      n++;
    end
    chk("toggle_valid_cycles", vcnt, 32);
    chk("toggle_beats", log_n - base, 16);
    for (int k = 0; k < 16; k++) chk("toggle_value", lx[(base + k) & 255], k);

    // two frames back-to-back with in_valid held
    base = log_n; c0 = cap_n;
    out_ready = 1'b1; in_data = 64'h0123_4567_89AB_CDEF; in_valid = 1'b1;
    tick();
    in_data = 64'h5A3C_96E1_F00F_7BD2;
    n = 0;
    while (cap_n < c0 + 2 && n < 60) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    wait_ready(n);
    chk("b2b_gap", cap_cyc[(c0 + 1) & 15] - cap_cyc[c0 & 15], 17);
    chk("b2b_beats", log_n - base, 32);
    chk("b2b_first", lx[base & 255], 4'hF);
    chk("b2b_second", lx[(base + 16) & 255], 4'h2);

    // reset while beat 7 is on the outputs
    in_data = 64'hFEDC_BA98_7654_3210; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    chk("mid_beat7", out1 ^ out2 ^ out3, 4'h7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_shares", {out_last, out1, out2, out3}, 13'd0);
    chk("mid_rst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("restart_beat0", {out1, out2, out3}, 12'hE86);
    wait_ready(n);
    chk("restart_done", in_ready, 1'b1);

`ifdef SEED_LOAD_EN
    seed_load = 1'b1; seed_data = 32'd0; in_valid = 1'b1;
    #1;
    chk("seed_in_ready", in_ready, 1'b0);
    tick();
    seed_load = 1'b0;
    chk("seed_no_capture", busy, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("seed_capture", {out1, out2, out3}, 12'hE86);
    wait_ready(n);
    chk("seed_frame_done", in_ready, 1'b1);
`endif

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
